// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI4-Lite master command interface.
package axil_pkg;

  localparam int AXIL_ADDR_W = 16;
  localparam int AXIL_DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WADDR_DATA,
    WRESP,
    RADDR,
    RDATA,
    RSP
  } axil_state_e;

endpackage

// File: rtl/axil_master_itf.sv
// AXI4-Lite master: turns one local command at a time into an AXI-Lite
// read or write and returns the slave's response on a valid/ready port.
// Every AXI and response output comes straight from a flop.
module axil_master_itf
  import axil_pkg::*;
#(
  parameter int ADDR_W = AXIL_ADDR_W,
  parameter int DATA_W = AXIL_DATA_W
) (
  input  logic                  M_AXI_ACLK,
  input  logic                  M_AXI_ARESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [ADDR_W-1:0]     M_AXI_AWADDR,
  output logic [2:0]            M_AXI_AWPROT,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,
  output logic [DATA_W-1:0]     M_AXI_WDATA,
  output logic [DATA_W/8-1:0]   M_AXI_WSTRB,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,
  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY,
  output logic [ADDR_W-1:0]     M_AXI_ARADDR,
  output logic [2:0]            M_AXI_ARPROT,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  input  logic [DATA_W-1:0]     M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY
);

  localparam int STRB_W = DATA_W / 8;

  axil_state_e         state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          resp_q, resp_d;

  // A channel counts as finished once its VALID is already down or it
  // handshakes this cycle; AW and W may complete in either order.
  logic aw_done, w_done;
  assign aw_done = !awvalid_q || M_AXI_AWREADY;
  assign w_done  = !wvalid_q  || M_AXI_WREADY;

  // Next-state and next-output logic for the single-outstanding FSM.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    resp_d      = resp_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          if (cmd_wr) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WADDR_DATA;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RADDR;
          end
        end
      end
      WADDR_DATA: begin
        if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = WRESP;
        end
      end
      WRESP: begin
        if (M_AXI_BVALID && bready_q) begin
          resp_d      = M_AXI_BRESP;
          rdata_d     = '0;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RADDR: begin
        if (arvalid_q && M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RDATA;
        end
      end
      RDATA: begin
        if (M_AXI_RVALID && rready_q) begin
          rdata_d     = M_AXI_RDATA;
          resp_d      = M_AXI_RRESP;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered so it reads 0 throughout reset and rises one edge after.
    cmd_ready_d = (state_d == IDLE);
  end

  // State and output registers; reset clears everything asynchronously so
  // any VALID in flight drops without waiting for a clock.
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      resp_q      <= RESP_OKAY;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axil_master_itf.sv
// Bench for axil_master_itf: a delay-programmable AXI-Lite slave with its own
// memory, a command-level reference memory, and protocol/stability checks.
module tb_axil_master_itf;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [15:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  axil_master_itf #(.ADDR_W(16), .DATA_W(32)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp),
    .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_ARADDR(araddr),
    .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready)
  );

  int checks = 0;
  int errors = 0;

  // slave configuration and state
  int        aw_dly, w_dly, b_dly, ar_dly, r_dly;
  logic [1:0] b_resp_cfg, r_resp_cfg;
  int        aw_seen, w_seen, ar_seen, b_cnt, r_cnt;
  bit        aw_got, w_got, b_pend, r_pend, spur;
  bit [15:0] s_awaddr, s_araddr;
  bit [31:0] s_wdata;
  bit [3:0]  s_wstrb;
  int        n_aw, n_w, n_b, n_ar, n_r;
  bit [31:0] slave_mem [bit [15:0]];
  bit [31:0] model_mem [bit [15:0]];

  // command queued behind a held cmd_valid
  logic        nxt_wr;
  logic [15:0] nxt_addr;
  logic [31:0] nxt_wdata;
  logic [3:0]  nxt_wstrb;

  function automatic bit [31:0] merge(input bit [31:0] old, input bit [31:0] d,
                                      input bit [3:0] s);
    bit [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic slave_clear();
    aw_seen = 0; w_seen = 0; ar_seen = 0; b_cnt = 0; r_cnt = 0;
    aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
    bresp = 0; rresp = 0; rdata = 0;
  endtask

  // One clock: note handshakes at the coming edge, advance to the next
  // falling edge, check hold/stability rules, then run the slave.
  task automatic tick();
    bit h_aw, h_w, h_b, h_ar, h_r;
    bit pend_aw, pend_w, pend_ar, pend_rsp, p_rst;
    logic [15:0] pa, par;
    logic [31:0] pwd, prd;
    logic [3:0]  pws;
    logic [1:0]  prs;
    h_aw = (awvalid === 1'b1) && (awready === 1'b1);
    h_w  = (wvalid  === 1'b1) && (wready  === 1'b1);
    h_b  = (bvalid  === 1'b1) && (bready  === 1'b1);
    h_ar = (arvalid === 1'b1) && (arready === 1'b1);
    h_r  = (rvalid  === 1'b1) && (rready  === 1'b1);
    pend_aw  = (awvalid === 1'b1) && !h_aw;
    pend_w   = (wvalid  === 1'b1) && !h_w;
    pend_ar  = (arvalid === 1'b1) && !h_ar;
    pend_rsp = (rsp_valid === 1'b1) && (rsp_ready !== 1'b1);
    pa = awaddr; par = araddr; pwd = wdata; pws = wstrb; prd = rsp_rdata; prs = rsp_resp;
    p_rst = rst;
    if (h_aw) s_awaddr = awaddr;
    if (h_w) begin s_wdata = wdata; s_wstrb = wstrb; end
    if (h_ar) s_araddr = araddr;
    @(posedge clk);
    @(negedge clk);
    if (!rst && !p_rst) begin
      if (pend_aw) begin
        chk("aw_valid_hold", 64'(awvalid), 64'd1);
        chk("aw_addr_stable", 64'(awaddr), 64'(pa));
      end
      if (pend_w) begin
        chk("w_valid_hold", 64'(wvalid), 64'd1);
        chk("w_data_stable", 64'(wdata), 64'(pwd));
        chk("w_strb_stable", 64'(wstrb), 64'(pws));
      end
      if (pend_ar) begin
        chk("ar_valid_hold", 64'(arvalid), 64'd1);
        chk("ar_addr_stable", 64'(araddr), 64'(par));
      end
      if (pend_rsp) begin
        chk("rsp_valid_hold", 64'(rsp_valid), 64'd1);
        chk("rsp_rdata_stable", 64'(rsp_rdata), 64'(prd));
        chk("rsp_resp_stable", 64'(rsp_resp), 64'(prs));
      end
    end
    if (rst) begin
      slave_clear();
      return;
    end
    if (h_aw) begin n_aw++; aw_got = 1; end
    if (h_w)  begin n_w++;  w_got  = 1; end
    if (aw_got && w_got) begin
      slave_mem[s_awaddr] = merge(slave_mem.exists(s_awaddr) ? slave_mem[s_awaddr] : 32'h0,
                                  s_wdata, s_wstrb);
      aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0;
    end
    if (h_b) begin n_b++; bvalid = 0; end
    if (h_ar) begin n_ar++; r_pend = 1; r_cnt = 0; end
    if (h_r) begin n_r++; rvalid = 0; end
    if (awvalid === 1'b1) begin awready = (aw_seen >= aw_dly); aw_seen++; end
    else begin awready = 0; aw_seen = 0; end
    if (wvalid === 1'b1) begin wready = (w_seen >= w_dly); w_seen++; end
    else begin wready = 0; w_seen = 0; end
    if (arvalid === 1'b1) begin arready = (ar_seen >= ar_dly); ar_seen++; end
    else begin arready = 0; ar_seen = 0; end
    if (b_pend) begin
      if (b_cnt >= b_dly) begin bvalid = 1; bresp = b_resp_cfg; b_pend = 0; end
      else b_cnt++;
    end
    if (r_pend) begin
      if (r_cnt >= r_dly) begin
        rvalid = 1; rresp = r_resp_cfg; r_pend = 0;
        rdata = slave_mem.exists(s_araddr) ? slave_mem[s_araddr] : 32'h0;
      end else r_cnt++;
    end
    if (spur) begin bvalid = 1; rvalid = 1; end
    if (!bvalid) bresp = 2'($urandom);
    if (!rvalid) begin rdata = $urandom; rresp = 2'($urandom); end
  endtask

  // Issue one command, wait for its response, compare against the model.
  // Latency counts edges from accept to rsp_valid; with a zero-wait slave
  // rsp_valid shows in the fourth cycle counting the accept cycle as first.
  task automatic run_txn(input bit wr, input logic [15:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input logic [1:0] resp,
                         input int d0, input int d1, input int d2, input int hold,
                         input bit b2b, input bit keep, input string tag);
    int n, lat, exp_lat;
    logic [31:0] exp_rdata;
    if (wr) begin aw_dly = d0; w_dly = d1; b_dly = d2; b_resp_cfg = resp; end
    else begin ar_dly = d0; r_dly = d2; r_resp_cfg = resp; end
    n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
    if (!b2b) begin
      cmd_wr = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb; cmd_valid = 1;
    end
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin tick(); n++; end
    if (b2b) chk({tag, "_b2b_gap"}, 64'(n), 64'd0);
    chk({tag, "_accept"}, 64'(cmd_ready), 64'd1);
    if (wr) begin
      exp_rdata = 32'h0;
      model_mem[addr] = merge(model_mem.exists(addr) ? model_mem[addr] : 32'h0, data, strb);
      exp_lat = 3 + ((d0 > d1) ? d0 : d1) + d2;
    end else begin
      exp_rdata = model_mem.exists(addr) ? model_mem[addr] : 32'h0;
      exp_lat = 3 + d0 + d2;
    end
    tick();
    if (keep) begin
      cmd_wr = nxt_wr; cmd_addr = nxt_addr; cmd_wdata = nxt_wdata; cmd_wstrb = nxt_wstrb;
    end else cmd_valid = 0;
    chk({tag, "_busy"}, 64'(cmd_ready), 64'd0);
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 100) begin tick(); lat++; end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_rdata"}, 64'(rsp_rdata), 64'(exp_rdata));
    chk({tag, "_resp"}, 64'(rsp_resp), 64'(resp));
    for (int i = 0; i < hold; i++) begin
      chk({tag, "_ready_low_in_rsp"}, 64'(cmd_ready), 64'd0);
      tick();
    end
    chk({tag, "_rsp_held"}, 64'(rsp_valid), 64'd1);
    chk({tag, "_resp_held"}, 64'(rsp_resp), 64'(resp));
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk({tag, "_rsp_done"}, 64'(rsp_valid), 64'd0);
    if (wr) begin
      chk({tag, "_n_aw"}, 64'(n_aw), 64'd1);
      chk({tag, "_n_w"}, 64'(n_w), 64'd1);
      chk({tag, "_n_b"}, 64'(n_b), 64'd1);
      chk({tag, "_n_ar"}, 64'(n_ar), 64'd0);
    end else begin
      chk({tag, "_n_ar"}, 64'(n_ar), 64'd1);
      chk({tag, "_n_r"}, 64'(n_r), 64'd1);
      chk({tag, "_n_aw"}, 64'(n_aw), 64'd0);
    end
  endtask

  initial begin
    logic [1:0] resp_tab [3];
    int n;
    resp_tab[0] = 2'b00; resp_tab[1] = 2'b10; resp_tab[2] = 2'b11;
    rst = 1; spur = 0;
    cmd_valid = 0; cmd_wr = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
    b_resp_cfg = 0; r_resp_cfg = 0;
    slave_clear();
    slave_mem[16'h0024] = 32'hDEAD_BEEF;
    model_mem[16'h0024] = 32'hDEAD_BEEF;

    // reset state
    @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_valids", 64'({awvalid, wvalid, arvalid, rsp_valid}), 64'd0);
    chk("rst_readies", 64'({bready, rready}), 64'd0);
    chk("rst_addr", 64'({awaddr, araddr}), 64'd0);
    chk("rst_wdata", 64'({wdata, wstrb}), 64'd0);
    chk("rst_rsp", 64'({rsp_rdata, rsp_resp}), 64'd0);
    chk("prot", 64'({awprot, arprot}), 64'd0);
    tick();
    rst = 0;
    chk("rel_cmd_ready_0", 64'(cmd_ready), 64'd0);
    tick();
    chk("rel_cmd_ready_1", 64'(cmd_ready), 64'd1);

    // directed scenarios
    run_txn(1, 16'h0010, 32'hA5A5_0001, 4'hF, 2'b00, 0, 0, 0, 0, 0, 0, "wr_zero_wait");
    run_txn(1, 16'h0014, 32'h1234_5678, 4'hF, 2'b00, 0, 3, 0, 1, 0, 0, "wr_w_late");
    run_txn(0, 16'h0024, 32'h0, 4'h0, 2'b00, 0, 0, 2, 0, 0, 0, "rd_deadbeef");
    run_txn(1, 16'h0030, 32'h0BAD_F00D, 4'h5, 2'b10, 1, 0, 1, 5, 0, 0, "wr_slverr_hold");

    // BVALID/RVALID outside WRESP/RDATA are ignored
    spur = 1;
    tick(); tick(); tick();
    chk("spur_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("spur_readies", 64'({bready, rready}), 64'd0);
    chk("spur_cmd_ready", 64'(cmd_ready), 64'd1);
    spur = 0; bvalid = 0; rvalid = 0;
    tick();

    // reset while in RADDR
    ar_dly = 10;
    cmd_wr = 0; cmd_addr = 16'h0024; cmd_valid = 1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin tick(); n++; end
    tick();
    cmd_valid = 0;
    chk("raddr_arvalid", 64'(arvalid), 64'd1);
    rst = 1;
    #1;
    chk("async_arvalid", 64'(arvalid), 64'd0);
    chk("async_cmd_ready", 64'(cmd_ready), 64'd0);
    tick(); tick();
    rst = 0;
    chk("arst_cmd_ready_0", 64'(cmd_ready), 64'd0);
    tick();
    chk("arst_cmd_ready_1", 64'(cmd_ready), 64'd1);
    for (int i = 0; i < 6; i++) begin
      chk("arst_no_rsp", 64'({rsp_valid, arvalid, rready}), 64'd0);
      tick();
    end

    // back-to-back write then read with cmd_valid held
    nxt_wr = 0; nxt_addr = 16'h0010; nxt_wdata = 32'h0; nxt_wstrb = 4'h0;
    run_txn(1, 16'h0010, 32'h00C3_0000, 4'h4, 2'b00, 0, 0, 0, 0, 0, 1, "b2b_wr");
    run_txn(0, 16'h0010, 32'h0, 4'h0, 2'b00, 0, 0, 0, 0, 1, 0, "b2b_rd");

    // randomized traffic against the reference memory
    for (int t = 0; t < 24; t++) begin
      bit          wr;
      logic [15:0] a;
      wr = 1'($urandom);
      a = 16'h0100 + 16'($urandom_range(0, 7) * 4);
      run_txn(wr, a, $urandom, 4'($urandom_range(1, 15)), resp_tab[$urandom_range(0, 2)],
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 2), 0, 0, wr ? "rand_wr" : "rand_rd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
